aes_key_sched_ctrl: RTL and testbench

//  Iterative AES-128 key-schedule controller: accepts a cipher key over a valid/ready handshake,

---
 rtl/aes_key_sched_ctrl_pkg.sv | 47 ++++
 rtl/aes_key_sched_ctrl_if.sv | 27 ++
 rtl/aes_key_sched_ctrl_sbox.sv | 30 +++
 rtl/aes_key_sched_ctrl.sv | 147 ++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared AES key-schedule definitions: round counts, FSM states and
// small GF(2^8) / round-constant helpers used by the schedule datapath.
package aes_key_sched_ctrl_pkg;

    localparam int AES_NR = 10;
    localparam int AES_NK = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } aes_state_e;

    // Round constant for round index 1..10; anything else yields zero.
    function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1 (shift-and-add).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Key-load, status and round-key read bus between the cipher core
// (master) and the key-schedule controller (slave).
interface aes_key_sched_ctrl_if #(
    parameter int AW = 4
);
    logic          key_valid;
    logic          key_ready;
    logic [127:0]  key;
    logic          clear;
    logic          busy;
    logic          keys_valid;
    logic          done;
    logic          rk_rd_en;
    logic [AW-1:0] rk_rd_addr;
    logic [127:0]  rk_rd_data;
    logic          rk_rd_valid;

    modport master (
        output key_valid, key, clear, rk_rd_en, rk_rd_addr,
        input  key_ready, busy, keys_valid, done, rk_rd_data, rk_rd_valid
    );

    modport slave (
        input  key_valid, key, clear, rk_rd_en, rk_rd_addr,
        output key_ready, busy, keys_valid, done, rk_rd_data, rk_rd_valid
    );
endinterface

// File: rtl/aes_key_sched_ctrl_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by
// the affine transform. Shared by the key schedule and SubBytes.
module aes_sbox
    import aes_key_sched_ctrl_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [7:0] inv;
    logic [7:0] sq;

    // Inverse as x^254 = product of x^(2^i) for i=1..7 (zero maps to zero),
    // then the affine map y = x ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    always_comb begin
        sq  = din;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        dout = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key schedule: one round key per clock through a
// single 4-S-box SubWord unit, 11-entry round-key file, registered read.
module aes_key_sched_ctrl
    import aes_key_sched_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NR,
    parameter int AW         = 4
) (
    input logic                 clk,
    input logic                 rst,
    aes_key_sched_ctrl_if.slave bus
);

    if (NUM_ROUNDS != AES_NR) begin : g_bad_rounds
        $error("aes_key_sched_ctrl: only NUM_ROUNDS=10 (AES-128) is supported");
    end
    if ((1 << AW) <= NUM_ROUNDS) begin : g_bad_aw
        $error("aes_key_sched_ctrl: AW too narrow to address all round keys");
    end

    aes_state_e   state;
    aes_state_e   state_nxt;
    logic [3:0]   rnd;
    logic [127:0] work;
    logic [127:0] next_work;
    logic [127:0] rk [0:NUM_ROUNDS];
    logic         keys_valid_q;
    logic         busy_q;
    logic         done_q;
    logic [127:0] rd_data_q;
    logic         rd_valid_q;
    logic         key_ready_w;
    logic         accept;
    logic         last_step;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  t_word;
    logic [31:0]  n0, n1, n2, n3;

    assign key_ready_w = (state == ST_IDLE) && !bus.clear;
    assign accept      = bus.key_valid && key_ready_w;
    assign last_step   = (state == ST_EXPAND) && (rnd == 4'(NUM_ROUNDS));
    assign rot_word    = {work[23:0], work[31:24]};

    for (genvar g = 0; g < AES_NK; g++) begin : g_subword
        aes_sbox u_sbox (
            .din  (rot_word[8*g +: 8]),
            .dout (sub_word[8*g +: 8])
        );
    end

    // Next round key from the previous one: each word chains on the one before.
    always_comb begin
        t_word    = sub_word ^ {aes_rcon(rnd), 24'h0};
        n0        = work[127:96] ^ t_word;
        n1        = work[95:64]  ^ n0;
        n2        = work[63:32]  ^ n1;
        n3        = work[31:0]   ^ n2;
        next_work = {n0, n1, n2, n3};
    end

    // Next-state logic: clear always returns to IDLE, otherwise load then expand.
    always_comb begin
        state_nxt = state;
        if (bus.clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (accept)    state_nxt = ST_EXPAND;
                ST_EXPAND: if (last_step) state_nxt = ST_IDLE;
                default:                  state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round-key file, working key and status flags; clear zeroizes key material.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
            work         <= '0;
            rnd          <= '0;
            keys_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (bus.clear) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
            work         <= '0;
            rnd          <= '0;
            keys_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                rk[0]        <= bus.key;
                work         <= bus.key;
                rnd          <= 4'd1;
                keys_valid_q <= 1'b0;
                busy_q       <= 1'b1;
            end else if (state == ST_EXPAND) begin
                rk[rnd] <= next_work;
                work    <= next_work;
                if (last_step) begin
                    busy_q       <= 1'b0;
                    keys_valid_q <= 1'b1;
                    done_q       <= 1'b1;
                end else begin
                    rnd <= rnd + 4'd1;
                end
            end
        end
    end

    // Registered read port; out-of-range indices return zero, idle cycles hold data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rk_rd_en && keys_valid_q;
            if (bus.rk_rd_en) begin
                if (int'(bus.rk_rd_addr) <= NUM_ROUNDS) begin
                    rd_data_q <= rk[bus.rk_rd_addr];
                end else begin
                    rd_data_q <= '0;
                end
            end
        end
    end

    assign bus.key_ready   = key_ready_w;
    assign bus.busy        = busy_q;
    assign bus.keys_valid  = keys_valid_q;
    assign bus.done        = done_q;
    assign bus.rk_rd_data  = rd_data_q;
    assign bus.rk_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: known-answer table, random
// keys against a FIPS-197 style key-expansion model, and corner sequences.
module tb_aes_key_sched_ctrl;

    logic clk;
    logic rst;

    aes_key_sched_ctrl_if #(.AW(4)) bus ();

    aes_key_sched_ctrl #(
        .NUM_ROUNDS (10),
        .AW         (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] rk1;
        logic [127:0] rk10;
    } vec_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    vec_t         vecs [2];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [7:0]   sbox_m [256];
    logic [7:0]   rcon_m [11];
    logic [127:0] model_rk [11];
    logic [127:0] fips_rk1;
    logic [127:0] fips_rk10;

    // Polynomial product followed by long-division reduction by 0x11b.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    // S-box by brute-force inverse search plus the bitwise affine formula.
    task automatic build_model_tables();
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int b = 0; b < 8; b++) begin
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8]
                     ^ inv[(b+7)%8] ^ c[b];
            end
            sbox_m[x] = s;
        end
        rcon_m[0] = 8'h00;
        rcon_m[1] = 8'h01;
        for (int j = 2; j < 11; j++) rcon_m[j] = ref_mul(rcon_m[j-1], 8'h02);
    endtask

    // Textbook word-by-word key expansion into model_rk[0..10].
    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] temp;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sbox_m[temp[31:24]], sbox_m[temp[23:16]],
                        sbox_m[temp[15:8]], sbox_m[temp[7:0]]};
                temp = temp ^ {rcon_m[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_flag(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Offer a key, then wait (bounded) for done; lat counts edges after acceptance.
    task automatic apply_stimulus(input logic [127:0] k, output int lat);
        bus.key       = k;
        bus.key_valid = 1'b1;
        check_flag("accept_ready", bus.key_ready, 1'b1);
        tick();
        bus.key_valid = 1'b0;
        check_flag("busy_after_accept", bus.busy, 1'b1);
        check_flag("keys_valid_drop", bus.keys_valid, 1'b0);
        lat = 0;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        check_output("done_latency", 128'(lat), 128'd10);
        check_flag("keys_valid_at_done", bus.keys_valid, 1'b1);
    endtask

    task automatic read_rk(input int addr, output logic [127:0] data, output logic valid);
        bus.rk_rd_en   = 1'b1;
        bus.rk_rd_addr = 4'(addr);
        tick();
        data           = bus.rk_rd_data;
        valid          = bus.rk_rd_valid;
        bus.rk_rd_en   = 1'b0;
    endtask

    // Back-to-back reads of every address against model_rk, zero beyond round 10.
    task automatic read_all(input string tag, input logic exp_valid);
        logic [127:0] exp;
        bus.rk_rd_en = 1'b1;
        for (int a = 0; a < 16; a++) begin
            bus.rk_rd_addr = 4'(a);
            tick();
            exp = (a <= 10) ? model_rk[a] : 128'h0;
            check_output($sformatf("%s_rk%0d", tag, a), bus.rk_rd_data, exp);
            check_flag($sformatf("%s_valid%0d", tag, a), bus.rk_rd_valid, exp_valid);
        end
        bus.rk_rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int           lat;
        logic [127:0] d;
        logic         v;
        logic [127:0] k2;

        fips_rk1  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        vecs[0] = '{key: FIPS_KEY, rk1: fips_rk1, rk10: fips_rk10};
        vecs[1] = '{key: 128'h0,
                    rk1: 128'h62636363626363636263636362636363,
                    rk10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        rst            = 1'b1;
        bus.key_valid  = 1'b0;
        bus.key        = '0;
        bus.clear      = 1'b0;
        bus.rk_rd_en   = 1'b0;
        bus.rk_rd_addr = '0;
        build_model_tables();
        $display("[TB] starting");

        #12;
        check_flag("rst_key_ready", bus.key_ready, 1'b1);
        check_flag("rst_busy", bus.busy, 1'b0);
        check_flag("rst_keys_valid", bus.keys_valid, 1'b0);
        check_flag("rst_done", bus.done, 1'b0);
        check_flag("rst_rd_valid", bus.rk_rd_valid, 1'b0);
        check_output("rst_rd_data", bus.rk_rd_data, 128'h0);
        tick();
        rst = 1'b0;
        tick();

        // Known-answer table.
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(vecs[i].key, lat);
            tick();
            check_flag($sformatf("vec%0d_done_pulse", i), bus.done, 1'b0);
            check_flag($sformatf("vec%0d_kv_hold", i), bus.keys_valid, 1'b1);
            read_rk(0, d, v);
            check_output($sformatf("vec%0d_rk0", i), d, vecs[i].key);
            read_rk(1, d, v);
            check_output($sformatf("vec%0d_rk1", i), d, vecs[i].rk1);
            check_flag($sformatf("vec%0d_rk1_valid", i), v, 1'b1);
            read_rk(10, d, v);
            check_output($sformatf("vec%0d_rk10", i), d, vecs[i].rk10);
        end

        // Random keys against the reference expansion.
        for (int i = 0; i < 3; i++) begin
            k2 = {$urandom, $urandom, $urandom, $urandom};
            model_expand(k2);
            apply_stimulus(k2, lat);
            read_all($sformatf("rand%0d", i), 1'b1);
        end

        // Key held during expansion is ignored, then accepted right after done.
        k2 = {$urandom, $urandom, $urandom, $urandom};
        bus.key       = FIPS_KEY;
        bus.key_valid = 1'b1;
        tick();
        bus.key = k2;
        begin
            int ready_seen;
            int kv_seen;
            ready_seen = 0;
            kv_seen    = 0;
            lat        = 0;
            while (!bus.done && lat < 20) begin
                if (bus.key_ready) ready_seen++;
                if (bus.keys_valid) kv_seen++;
                tick();
                lat++;
            end
            check_output("hold_ready_seen", 128'(ready_seen), 128'd0);
            check_output("hold_kv_seen", 128'(kv_seen), 128'd0);
            check_output("hold_latency", 128'(lat), 128'd10);
        end
        check_flag("hold_ready_after_done", bus.key_ready, 1'b1);
        bus.rk_rd_en   = 1'b1;
        bus.rk_rd_addr = 4'd1;
        tick();
        check_flag("rekey_busy", bus.busy, 1'b1);
        check_output("hold_rk1_old", bus.rk_rd_data, fips_rk1);
        check_flag("hold_rk1_valid", bus.rk_rd_valid, 1'b1);
        bus.rk_rd_addr = 4'd10;
        tick();
        bus.rk_rd_en  = 1'b0;
        bus.key_valid = 1'b0;
        check_output("hold_rk10_old", bus.rk_rd_data, fips_rk10);
        check_flag("hold_rk10_valid", bus.rk_rd_valid, 1'b0);
        check_flag("rekey_kv_low", bus.keys_valid, 1'b0);
        lat = 1;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        check_output("rekey_latency", 128'(lat), 128'd10);
        model_expand(k2);
        read_all("rekey", 1'b1);

        // Clear at E5 aborts and zeroizes; accept is blocked while clear is high.
        bus.key       = {$urandom, $urandom, $urandom, $urandom};
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_flag("clr_busy_before", bus.busy, 1'b1);
        bus.clear = 1'b1;
        tick();
        check_flag("clr_busy", bus.busy, 1'b0);
        check_flag("clr_keys_valid", bus.keys_valid, 1'b0);
        check_flag("clr_done", bus.done, 1'b0);
        bus.key_valid = 1'b1;
        check_flag("clr_ready_blocked", bus.key_ready, 1'b0);
        tick();
        check_flag("clr_no_accept", bus.busy, 1'b0);
        bus.key_valid = 1'b0;
        bus.clear     = 1'b0;
        for (int r = 0; r < 11; r++) model_rk[r] = 128'h0;
        read_all("clr", 1'b0);
        k2 = {$urandom, $urandom, $urandom, $urandom};
        model_expand(k2);
        apply_stimulus(k2, lat);
        read_all("postclr", 1'b1);

        // Asynchronous reset in the middle of a cycle during expansion.
        read_rk(1, d, v);
        bus.key       = FIPS_KEY;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        tick();
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        check_flag("arst_busy", bus.busy, 1'b0);
        check_flag("arst_keys_valid", bus.keys_valid, 1'b0);
        check_flag("arst_done", bus.done, 1'b0);
        check_flag("arst_ready", bus.key_ready, 1'b1);
        check_flag("arst_rd_valid", bus.rk_rd_valid, 1'b0);
        check_output("arst_rd_data", bus.rk_rd_data, 128'h0);
        #2;
        rst = 1'b0;
        tick();
        for (int r = 0; r < 11; r++) model_rk[r] = 128'h0;
        read_all("arst", 1'b0);

        // Restart with the FIPS key and sweep all 16 addresses back to back.
        model_expand(FIPS_KEY);
        apply_stimulus(FIPS_KEY, lat);
        read_all("fips", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
